// File: rtl/seq_feeder_pkg.sv
// seq_feeder_pkg: shared definitions for the Smith-Waterman query/reference
// feeder. It holds the base encoding, the filler base, the controller state
// encoding and a helper that sizes a counter for an inclusive maximum value.
package seq_feeder_pkg;

  localparam int BASE_W = 3;

  // Filler base. The loader never sends it, so it mismatches every
  // reference base and a PE fed with it scores nothing.
  localparam logic [BASE_W-1:0] PAD_BASE = 3'b111;

  localparam logic [BASE_W-1:0] BASE_A = 3'b000;
  localparam logic [BASE_W-1:0] BASE_C = 3'b001;
  localparam logic [BASE_W-1:0] BASE_G = 3'b010;
  localparam logic [BASE_W-1:0] BASE_T = 3'b011;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_REF = 3'd1,
    LOAD_QRY = 3'd2,
    CLEAR    = 3'd3,
    RUN      = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_feeder_qi_skew_shifter.sv
// qi_skew_shifter: NUM_PE-stage shift register of bases that produces the
// diagonally skewed query stream. Stage 0 takes din, stage k takes stage k-1,
// so PE k sees each query base one cycle after PE k-1.
// Ports:
//   clk, reset   clock, asynchronous active-low reset (all stages -> PAD_BASE)
//   clr          load PAD_BASE into every stage (has priority over shift_en)
//   shift_en     shift one stage and load din into stage 0
//   din          base entering stage 0
//   qi_bus       slice k = stage k
module qi_skew_shifter
  import seq_feeder_pkg::*;
#(
  parameter int NUM_PE = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     shift_en,
  input  logic [BASE_W-1:0]        din,
  output logic [NUM_PE*BASE_W-1:0] qi_bus
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qi_bus <= {NUM_PE{PAD_BASE}};
    end else if (clr) begin
      qi_bus <= {NUM_PE{PAD_BASE}};
    end else if (shift_en) begin
      qi_bus <= {qi_bus[(NUM_PE-1)*BASE_W-1:0], din};
    end
  end

endmodule

// File: rtl/seq_feeder.sv
// seq_feeder: transmit-side driver for the Smith-Waterman systolic PE array.
// Loads NUM_PE reference bases then a query (up to MAX_QLEN bases) from one
// byte stream, clears the array for one cycle, then streams the skewed query
// for qlen+NUM_PE-1 cycles and pulses done.
//
// Handshake: a base is transferred on a rising clk edge where s_valid and
// s_ready are both high; s_base/s_last are only meaningful while s_valid is
// high, and the source must hold them until the transfer. s_ready is high
// only in LOAD_REF and LOAD_QRY and never depends combinationally on s_valid.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start             run request, sampled only in IDLE
//   s_valid/s_ready/s_base/s_last   input base stream
//   ri_bus            slice k = reference base of PE k (static during a run)
//   qi_bus            slice k = query base of PE k (skewed)
//   pe_reset          synchronous clear to the PE array (CLEAR state)
//   col_valid         high in every RUN cycle
//   busy              high outside IDLE
//   done              one-cycle pulse in DONE
//   qlen              accepted query length, held until next start
//   ovf               (SEQ_FEEDER_OVF_EN only) sticky query-truncation flag
//   dbg_state         current controller state (state_t encoding)
// Optional feature macro: SEQ_FEEDER_OVF_EN.
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int NUM_PE   = 8,
  parameter int MAX_QLEN = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [BASE_W-1:0]           s_base,
  input  logic                        s_last,
  output logic [NUM_PE*BASE_W-1:0]    ri_bus,
  output logic [NUM_PE*BASE_W-1:0]    qi_bus,
  output logic                        pe_reset,
  output logic                        col_valid,
  output logic                        busy,
  output logic                        done,
  output logic [cnt_w(MAX_QLEN)-1:0]  qlen,
`ifdef SEQ_FEEDER_OVF_EN
  output logic                        ovf,
`endif
  output logic [2:0]                  dbg_state
);

  localparam int QL_W  = cnt_w(MAX_QLEN);
  localparam int QA_W  = $clog2(MAX_QLEN);
  localparam int RC_W  = $clog2(NUM_PE);
  localparam int T_W   = cnt_w(MAX_QLEN + NUM_PE - 2);
  // One wider than the last RUN index so t+1 never wraps.
  localparam int IDX_W = cnt_w(MAX_QLEN + NUM_PE - 1);

  state_t state, next_state;

  logic [RC_W-1:0]   ref_cnt;
  logic [BASE_W-1:0] ref_buf [NUM_PE];
  logic [BASE_W-1:0] q_buf   [MAX_QLEN];
  logic [T_W-1:0]    t_cnt;

  logic              xfer;
  logic              ref_last;
  logic              qry_end;
  logic              run_last;
  logic [IDX_W-1:0]  feed_idx;
  logic              sh_clr;
  logic              sh_en;
  logic [BASE_W-1:0] sh_din;

  logic s_ready_d, pe_reset_d, col_valid_d, busy_d, done_d;

  assign xfer      = s_valid && s_ready;
  assign ref_last  = (ref_cnt == RC_W'(NUM_PE - 1));
  assign qry_end   = s_last || (qlen == QL_W'(MAX_QLEN - 1));
  assign run_last  = (IDX_W'(t_cnt) == IDX_W'(qlen) + IDX_W'(NUM_PE - 2));
  assign dbg_state = state;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start)             next_state = LOAD_REF;
      LOAD_REF: if (xfer && ref_last)  next_state = LOAD_QRY;
      LOAD_QRY: if (xfer && qry_end)   next_state = CLEAR;
      CLEAR:                           next_state = RUN;
      RUN:      if (run_last)          next_state = DONE;
      DONE:                            next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  // Outputs are decoded from next_state and registered, so each one is a
  // clean flop that reflects the state the controller is in this cycle.
  always_comb begin
    s_ready_d   = (next_state == LOAD_REF) || (next_state == LOAD_QRY);
    pe_reset_d  = (next_state == CLEAR);
    col_valid_d = (next_state == RUN);
    busy_d      = (next_state != IDLE);
    done_d      = (next_state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready   <= 1'b0;
      pe_reset  <= 1'b0;
      col_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      s_ready   <= s_ready_d;
      pe_reset  <= pe_reset_d;
      col_valid <= col_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // ---------------- buffers and counters ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
      qlen    <= '0;
      t_cnt   <= '0;
      ri_bus  <= '0;
      for (int i = 0; i < NUM_PE; i++)   ref_buf[i] <= '0;
      for (int i = 0; i < MAX_QLEN; i++) q_buf[i]   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ref_cnt <= '0;
            qlen    <= '0;
          end
        end
        LOAD_REF: begin
          if (xfer) begin
            ref_buf[ref_cnt] <= s_base;
            if (!ref_last) begin
              ref_cnt <= ref_cnt + RC_W'(1);
            end else begin
              // Publish the whole window at once; the final base comes
              // straight from the stream since ref_buf is not yet updated.
              for (int k = 0; k < NUM_PE - 1; k++)
                ri_bus[k*BASE_W +: BASE_W] <= ref_buf[k];
              ri_bus[(NUM_PE-1)*BASE_W +: BASE_W] <= s_base;
            end
          end
        end
        LOAD_QRY: begin
          if (xfer) begin
            q_buf[qlen[QA_W-1:0]] <= s_base;
            qlen                  <= qlen + QL_W'(1);
          end
        end
        CLEAR: t_cnt <= '0;
        RUN:   if (!run_last) t_cnt <= t_cnt + T_W'(1);
        default: ;
      endcase
    end
  end

`ifdef SEQ_FEEDER_OVF_EN
  // Truncation: the MAX_QLEN-th base arrived without s_last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf <= 1'b0;
    end else if (state == LOAD_QRY && xfer && !s_last &&
                 qlen == QL_W'(MAX_QLEN - 1)) begin
      ovf <= 1'b1;
    end
  end
`endif

  // ---------------- skewed query feed ----------------
  // The shifter load at the edge entering RUN cycle t must carry q[t]:
  // index 0 when leaving CLEAR, t+1 while in RUN. Past the query end the
  // feed is PAD_BASE so the tail of the diagonal drains cleanly.
  assign feed_idx = (state == CLEAR) ? '0 : IDX_W'(t_cnt) + IDX_W'(1);
  assign sh_din   = (feed_idx < IDX_W'(qlen)) ? q_buf[feed_idx[QA_W-1:0]]
                                              : PAD_BASE;
  assign sh_clr   = (next_state != RUN);
  assign sh_en    = (next_state == RUN);

  qi_skew_shifter #(
    .NUM_PE (NUM_PE)
  ) u_qi_skew_shifter (
    .clk      (clk),
    .reset    (reset),
    .clr      (sh_clr),
    .shift_en (sh_en),
    .din      (sh_din),
    .qi_bus   (qi_bus)
  );

endmodule

// File: tb/tb_seq_feeder.sv
// tb_seq_feeder: self-checking bench for seq_feeder (NUM_PE=8, MAX_QLEN=32).
// A job table drives directed runs; random jobs follow. The expected qi_bus
// column sequence of every run is computed from the accepted query and fed
// to a scoreboard queue that the negedge monitor drains.
module tb_seq_feeder;
  import seq_feeder_pkg::*;

  localparam int NUM_PE   = 8;
  localparam int MAX_QLEN = 32;
  localparam int W        = NUM_PE * BASE_W;
  localparam logic [W-1:0] PAD_ALL = {NUM_PE{PAD_BASE}};
  localparam logic [W-1:0] REF_ACGT =
    {BASE_T, BASE_G, BASE_C, BASE_A, BASE_T, BASE_G, BASE_C, BASE_A};
  localparam logic [W-1:0] REF_TTGG =
    {BASE_A, BASE_A, BASE_C, BASE_C, BASE_G, BASE_G, BASE_T, BASE_T};
  // Nominal GATT run at t=3: slice0=T, slice1=T, slice2=A, slice3=G.
  localparam logic [W-1:0] NOM_T3 =
    {PAD_BASE, PAD_BASE, PAD_BASE, PAD_BASE, BASE_G, BASE_A, BASE_T, BASE_T};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic [BASE_W-1:0] s_base = '0;
  logic              s_ready, pe_reset, col_valid, busy, done;
  logic [W-1:0]      ri_bus, qi_bus;
  logic [5:0]        qlen;
  logic [2:0]        dbg_state;
`ifdef SEQ_FEEDER_OVF_EN
  logic              ovf;
`endif

  seq_feeder #(.NUM_PE(NUM_PE), .MAX_QLEN(MAX_QLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_base    (s_base),
    .s_last    (s_last),
    .ri_bus    (ri_bus),
    .qi_bus    (qi_bus),
    .pe_reset  (pe_reset),
    .col_valid (col_valid),
    .busy      (busy),
    .done      (done),
    .qlen      (qlen),
`ifdef SEQ_FEEDER_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- job description ----------------
  typedef struct {
    logic [W-1:0] ref_w;
    int           n_q;
    bit           fixed_q;
    bit           use_last;
    int           bp;       // 0 always valid, 1 toggling, 2 random
    bit           st_q;     // pulse start during LOAD_QRY
    bit           st_d;     // pulse start during DONE
    bit           abort;    // reset during RUN t=3
    int           e_qlen;
    int           e_cols;
    bit           e_ovf;
  } job_t;

  job_t tbl[8];
  logic [BASE_W-1:0] gatt[4];

  logic [W-1:0]      job_ref;
  logic [BASE_W-1:0] job_q[$];
  bit                job_last, job_st_q, job_st_d, job_abort;
  int                job_bp, job_idx;
  int                exp_qlen, exp_cols;
  bit                exp_ovf;
  logic [W-1:0]      exp_ri;
  logic [W-1:0]      prev_ri = '0;

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int col_cnt, done_cnt, clr_cnt, ci;
  bit mon_en = 1'b0;

  function automatic int model_len(input int n);
    return (n < MAX_QLEN) ? n : MAX_QLEN;
  endfunction

  // Column t: PE k holds query base t-k when it exists, else PAD.
  task automatic build_expect();
    int l;
    logic [W-1:0] w;
    l = model_len(job_q.size());
    exp_q.delete();
    for (int t = 0; t < l + NUM_PE - 1; t++) begin
      for (int k = 0; k < NUM_PE; k++)
        w[k*BASE_W +: BASE_W] = (t - k >= 0 && t - k < l) ? job_q[t-k] : PAD_BASE;
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pe_reset) begin
        clr_cnt++;
        ci = 0;
        chk("qi_pad_in_clear", qi_bus, PAD_ALL);
        chk("ri_at_clear", ri_bus, exp_ri);
      end else begin
        ci++;
      end
      if (col_valid) begin
        col_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_column", 32'(col_cnt), 32'(exp_cols));
        end else begin
          chk("qi_column", qi_bus, exp_q.pop_front());
          chk("column_timing", 32'(ci), 32'(col_cnt));
        end
        if (job_idx <= 1 && col_cnt == 4) chk("nominal_t3", qi_bus, NOM_T3);
      end
      if (done) begin
        done_cnt++;
        chk("qi_pad_in_done", qi_bus, PAD_ALL);
        chk("columns_left_at_done", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_job();
    logic [BASE_W-1:0] sb[$];
    bit sl[$];
    int acc, need, budget, run_t;
    build_expect();
    exp_ri = job_ref;
    col_cnt = 0; done_cnt = 0; clr_cnt = 0; ci = 0;
    for (int k = 0; k < NUM_PE; k++) begin
      sb.push_back(job_ref[k*BASE_W +: BASE_W]);
      sl.push_back(1'($urandom_range(0, 1)));   // ignored during LOAD_REF
    end
    for (int i = 0; i < job_q.size(); i++) begin
      sb.push_back(job_q[i]);
      sl.push_back(job_last && (i == job_q.size() - 1));
    end
    need = NUM_PE + model_len(job_q.size());

    @(negedge clk);
    chk("idle_before_start", busy, 1'b0);
    start = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("ready_in_load_ref", s_ready, 1'b1);
    chk("qlen_cleared", qlen, 0);
    chk("ri_held_during_load", ri_bus, prev_ri);
`ifdef SEQ_FEEDER_OVF_EN
    chk("ovf_clear_on_start", ovf, 1'b0);
`endif

    acc = 0; budget = 0;
    while (acc < need && budget < 400) begin
      start = (job_st_q && acc == NUM_PE + 1);
      case (job_bp)
        0:       s_valid = 1'b1;
        1:       s_valid = (budget[0] == 1'b0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_base = sb[0];
      s_last = sl[0];
      if (s_valid && s_ready) begin
        void'(sb.pop_front());
        void'(sl.pop_front());
        acc++;
      end
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    chk("all_bases_accepted", 32'(acc), 32'(need));
    // Keep any surplus base presented: it must stay upstream.
    if (sb.size() > 0) begin
      s_valid = 1'b1; s_base = sb[0]; s_last = sl[0];
    end else begin
      s_valid = 1'b0;
    end
    chk("ready_low_after_query", s_ready, 1'b0);
    chk("pe_reset_after_query", pe_reset, 1'b1);

    run_t = 0; budget = 0;
    while (!done && budget < 200) begin
      @(negedge clk);
      s_valid = 1'b0;
      budget++;
      if (col_valid) run_t++;
      if (job_abort && run_t == 4) begin
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_qi_pad", qi_bus, PAD_ALL);
        chk("abort_col_valid", col_valid, 1'b0);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("abort_no_done", done, 1'b0);
          chk("abort_busy_low", busy, 1'b0);
        end
        chk("abort_qlen", qlen, 0);
        chk("abort_ri", ri_bus, 0);
        chk("abort_state", dbg_state, 32'(IDLE));
        mon_en = 1'b0;
        exp_q.delete();
        chk("abort_done_count", 32'(done_cnt), 32'd0);
        reset = 1'b1;
        prev_ri = '0;
        return;
      end
    end
    chk("done_seen", done, 1'b1);
    chk("col_low_in_done", col_valid, 1'b0);
    if (job_st_d) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_run", busy, 1'b0);
    chk("state_idle", dbg_state, 32'(IDLE));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("clear_cycles", 32'(clr_cnt), 32'd1);
    chk("run_cycles", 32'(col_cnt), 32'(exp_cols));
    chk("qlen_final", qlen, 32'(exp_qlen));
    chk("ri_final", ri_bus, exp_ri);
`ifdef SEQ_FEEDER_OVF_EN
    chk("ovf_final", ovf, exp_ovf);
`endif
    mon_en = 1'b0;
    prev_ri = exp_ri;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    gatt = '{BASE_G, BASE_A, BASE_T, BASE_T};
    //            ref       n   fix last bp stq std abt qlen cols ovf
    tbl[0] = '{REF_ACGT,  4, 1, 1, 0, 0, 0, 0,  4, 11, 0};
    tbl[1] = '{REF_ACGT,  4, 1, 1, 1, 0, 0, 0,  4, 11, 0};
    tbl[2] = '{REF_TTGG,  1, 0, 1, 0, 0, 0, 0,  1,  8, 0};
    tbl[3] = '{REF_ACGT, 33, 0, 0, 0, 0, 0, 0, 32, 39, 1};
    tbl[4] = '{REF_TTGG,  5, 0, 1, 0, 1, 1, 0,  5, 12, 0};
    tbl[5] = '{REF_ACGT, 32, 0, 1, 1, 0, 0, 0, 32, 39, 0};
    tbl[6] = '{REF_TTGG, 10, 0, 1, 2, 0, 0, 0, 10, 17, 0};
    tbl[7] = '{REF_ACGT,  6, 0, 1, 0, 0, 0, 1,  6, 13, 0};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_col_valid", col_valid, 1'b0);
    chk("rst_pe_reset", pe_reset, 1'b0);
    chk("rst_qi_pad", qi_bus, PAD_ALL);
    chk("rst_ri", ri_bus, 0);
    chk("rst_qlen", qlen, 0);
    chk("rst_state", dbg_state, 32'(IDLE));
`ifdef SEQ_FEEDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    reset = 1'b1;

    for (int j = 0; j < 8; j++) begin
      job_idx   = j;
      job_ref   = tbl[j].ref_w;
      job_q.delete();
      for (int i = 0; i < tbl[j].n_q; i++)
        job_q.push_back(tbl[j].fixed_q ? gatt[i] : BASE_W'($urandom_range(0, 3)));
      job_last  = tbl[j].use_last;
      job_bp    = tbl[j].bp;
      job_st_q  = tbl[j].st_q;
      job_st_d  = tbl[j].st_d;
      job_abort = tbl[j].abort;
      exp_qlen  = tbl[j].e_qlen;
      exp_cols  = tbl[j].e_cols;
      exp_ovf   = tbl[j].e_ovf;
      run_job();
    end

    for (int r = 0; r < 6; r++) begin
      int n;
      job_idx = 100 + r;
      for (int k = 0; k < NUM_PE; k++)
        job_ref[k*BASE_W +: BASE_W] = BASE_W'($urandom_range(0, 3));
      n = $urandom_range(1, 40);
      job_q.delete();
      for (int i = 0; i < n; i++) job_q.push_back(BASE_W'($urandom_range(0, 3)));
      job_last  = (n < MAX_QLEN) ? 1'b1 : 1'($urandom_range(0, 1));
      job_bp    = $urandom_range(0, 2);
      job_st_q  = 1'($urandom_range(0, 1));
      job_st_d  = 1'($urandom_range(0, 1));
      job_abort = 1'b0;
      exp_qlen  = model_len(n);
      exp_cols  = model_len(n) + NUM_PE - 1;
      exp_ovf   = job_last ? (n > MAX_QLEN) : (n >= MAX_QLEN);
      run_job();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_feeder.md
Name: seq_feeder

Overview:
- Transmit-side driver for the Smith-Waterman systolic PE array.
- Accepts a reference window and a query sequence over one valid/ready byte-stream, buffers them, then drives the array:
  - per-PE reference bases (ri), held static for the whole run;
  - diagonally skewed query bases (qi), PE k lagging PE k-1 by one cycle;
  - the array's synchronous clear.
- Sits between the host/DMA loader and the PE chain.

Parameters:
- NUM_PE, 8, number of PEs driven; also the number of reference bases per run.
- MAX_QLEN, 32, query buffer depth in bases.
- BASE_W, 3, bits per encoded base.
- PAD_BASE, 3'b111, filler base; the loader never sends it, so it mismatches every reference base.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- s_valid  in  1  input base valid.
- s_ready  out  1  input base ready.
- s_base  in  BASE_W  encoded base.
- s_last  in  1  marks the final query base.
- ri_bus  out  NUM_PE*BASE_W  slice k drives PE k ri.
- qi_bus  out  NUM_PE*BASE_W  slice k drives PE k qi.
- pe_reset  out  1  active-high synchronous clear to the PE array.
- col_valid  out  1  high during every RUN cycle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- qlen  out  $clog2(MAX_QLEN+1)  accepted query length, held until next start.

Behaviour:
- Reset values (asynchronous, reset=0):
  - state=IDLE.
  - All outputs 0, except qi_bus = all PAD_BASE.
  - ri_bus=0, ref/query buffers cleared, qlen=0.
- Reset asserted mid-operation aborts the run immediately with no done pulse.
- All outputs are registered. A transfer occurs when s_valid && s_ready on a rising clk edge.
- IDLE:
  - s_ready=0.
  - start=1: goes to LOAD_REF next cycle, ref_cnt=0, qlen=0.
- LOAD_REF:
  - s_ready=1.
  - Each transfer writes ref[ref_cnt], where ref_cnt counts 0..NUM_PE-1; s_last is ignored.
  - The NUM_PE-th transfer moves to LOAD_QRY.
  - ri_bus updates to the new window on the cycle after that final transfer.
- LOAD_QRY:
  - s_ready=1.
  - Each transfer writes q[qlen] and increments qlen.
  - A transfer with s_last=1, or the transfer that makes qlen==MAX_QLEN, moves to CLEAR. The MAX_QLEN case applies even without s_last.
  - qlen ≥ 1 is always true on exit.
- CLEAR (exactly one cycle):
  - pe_reset=1, s_ready=0, qi_bus = all PAD_BASE. Next state RUN, t=0.
- RUN (exactly qlen+NUM_PE-1 cycles, t=0..qlen+NUM_PE-2):
  - pe_reset=0, col_valid=1.
  - During cycle t, qi_bus slice k = q[t-k] when 0 ≤ t-k < qlen, else PAD_BASE.
  - Implemented as a NUM_PE-stage shift register whose stage 0 loads q[t] and stage k loads stage k-1.
  - The last cycle, where PE NUM_PE-1 sees q[qlen-1], moves to DONE.
- DONE:
  - done=1, col_valid=0, qi_bus returns to all PAD_BASE. Next state IDLE.
  - ri_bus holds its value until the next LOAD_REF completes.
- start outside IDLE is ignored, including start coincident with done.
- A start pulse is not queued.
- Counter widths are sized to the exact ranges above, with no wrap-around. The t counter must reach qlen+NUM_PE-2 without overflow.

Optional Feature:
- SEQ_FEEDER_OVF_EN: adds output ovf (1 bit, reset 0).
  - Set when the MAX_QLEN-th query base is accepted with s_last=0; the query was truncated.
  - Sticky; cleared on an accepted start.
  - The run proceeds normally on the truncated query.
- Without the macro:
  - the ovf port and its logic are absent;
  - truncation is silent, and the surplus bases remain upstream.

Decomposition:
- Package seq_feeder_pkg holds:
  - BASE_W, PAD_BASE, and the base encodings A/C/G/T;
  - the state enum (IDLE, LOAD_REF, LOAD_QRY, CLEAR, RUN, DONE);
  - a function computing the count width.
- One natural sub-module: qi_skew_shifter, the NUM_PE-stage base shift register with load-PAD and shift-enable controls.

Test Plan:
- Reset mid-RUN (NUM_PE=8): assert reset during t=3 → next edge busy=0, done never pulses, qi_bus all 3'b111.
- Nominal run:
  - Stimulus: start; ref ACGTACGT; query 4 bases GATT with s_last on the 4th.
  - pe_reset high for 1 cycle.
  - col_valid high 11 cycles.
  - At t=3: slice0=T, slice1=T, slice2=A, slice3=G, slices4-7=PAD.
  - done pulses once; qlen=4.
- Backpressure: s_valid toggling 1/0 every cycle during loads → identical qi_bus sequence and timing relative to CLEAR as the nominal run.
- Single-base query (s_last on first query base) → RUN lasts exactly 8 cycles; PE7 sees the base at t=7.
- Overflow (SEQ_FEEDER_OVF_EN, MAX_QLEN=32): send 33 query bases, no s_last → after the 32nd, s_ready=0; ovf=1; qlen=32; RUN lasts 39 cycles; ovf clears on next start.
- start ignored: pulse start during LOAD_QRY and during DONE → no state change, no second run.
